// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, 1-cycle imem reads, and a skid buffer.
// Delivers {instr,pc} to ID over valid/ready; EX redirects flush and restart.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready_I,
  input  logic        redirect_I,
  input  logic [31:0] redirect_pc_I,
  output logic        imem_req_O,
  output logic [31:0] imem_addr_O,
  input  logic [31:0] imem_rdata_I,
  output logic [31:0] instr_IF_O,
  output logic [31:0] pc_IF_O,
  output logic        valid_IF_O
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  fetch_t      out_q, out_d;
  logic        out_v_q, out_v_d;
  fetch_t      skid_q, skid_d;
  logic        skid_v_q, skid_v_d;

  logic        xfer;
  logic        stall_blk;
  logic        req;
  logic [31:0] redir_pc;
  logic [31:0] fetch_pc;
  fetch_t      resp;

  assign redir_pc  = redirect_pc_I & ~32'h3;
  assign xfer      = out_v_q & ready_I;
  assign stall_blk = pend_q & out_v_q & ~ready_I;
  // A read only issues when a landing slot is guaranteed next cycle.
  assign req       = rst_n & (redirect_I | (~skid_v_q & ~stall_blk));
  assign fetch_pc  = redirect_I ? redir_pc : pc_q;
  assign resp      = '{instr: imem_rdata_I, pc: pend_pc_q};

  assign imem_req_O  = req;
  assign imem_addr_O = fetch_pc;
  assign instr_IF_O  = out_v_q ? out_q.instr : NOP_INSTR;
  assign pc_IF_O     = out_q.pc;
  assign valid_IF_O  = out_v_q;

  // Next state: redirect flushes; else skid drains first, then response lands.
  always_comb begin
    pc_d      = pc_q;
    pend_d    = req;
    pend_pc_d = pend_pc_q;
    out_d     = out_q;
    out_v_d   = out_v_q;
    skid_d    = skid_q;
    skid_v_d  = skid_v_q;
    if (req) begin
      pc_d      = fetch_pc + 32'd4;
      pend_pc_d = fetch_pc;
    end
    if (redirect_I) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q && xfer) begin
      out_d    = skid_q;
      skid_v_d = 1'b0;
    end else if (pend_q) begin
      if (!out_v_q || xfer) begin
        out_d   = resp;
        out_v_d = 1'b1;
      end else begin
        skid_d   = resp;
        skid_v_d = 1'b1;
      end
    end else if (xfer) begin
      out_v_d = 1'b0;
    end
  end

  // State registers; reset drops every in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
      out_q     <= '{instr: NOP_INSTR, pc: 32'd0};
      out_v_q   <= 1'b0;
      skid_q    <= '{instr: NOP_INSTR, pc: 32'd0};
      skid_v_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      out_q     <= out_d;
      out_v_q   <= out_v_d;
      skid_q    <= skid_d;
      skid_v_q  <= skid_v_d;
    end
  end

endmodule
